pc_run_monitor: RTL and testbench

Synthesizable run-control monitor for the pipelined MIPS core; it watches the fetch-stage PC and decides when a program run is over. It generalises the bench-level "stop when PC+4 reaches the end of instruction memory" check with parametrised address window, arming delay, cycle-limit watchdog, hang detection and an external stop. Its sticky `halt` and latched cause/PC are meant for both the simulation bench (to call `$finish`) and FPGA debug.

---
 rtl/run_monitor_pkg.sv | 17 +
 rtl/sat_counter.sv | 36 +++
 rtl/pc_run_monitor.sv | 139 +++++++++++++
 tb/tb_pc_run_monitor.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// rtl/run_monitor_pkg.sv - state and halt-cause encodings shared by the PC run monitor
package run_monitor_pkg;

    localparam int CAUSE_W = 3;

    localparam logic [1:0] ST_ARM    = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE      = 3'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_END       = 3'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_UNDERFLOW = 3'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_HANG      = 3'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT   = 3'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_EXT       = 3'd5;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with clear that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // clear beats increment; increment stops once every bit is set
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_run_monitor.sv
// rtl/pc_run_monitor.sv - watches the fetch PC and latches why and where a program run ended
module pc_run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned      PC_W       = 32,
    parameter logic [PC_W-1:0]  START_ADDR = 'h3000,
    parameter logic [PC_W-1:0]  END_ADDR   = 'h4000,
    parameter int unsigned      ARM_DELAY  = 0,
    parameter int unsigned      CNT_W      = 32,
    parameter logic [CNT_W-1:0] MAX_CYCLES = '0,
    parameter logic [CNT_W-1:0] HANG_LIMIT = 'd1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc,
    input  logic               ext_stop,
    output logic               running,
    output logic               halt,
    output logic [CAUSE_W-1:0] halt_cause,
    output logic [PC_W-1:0]    halt_pc,
    output logic [CNT_W-1:0]   cycle_cnt
);

    localparam int ARM_W = (ARM_DELAY > 0) ? $clog2(ARM_DELAY + 1) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST   = ARM_W'(ARM_DELAY);
    localparam logic [PC_W:0]    PC_STEP    = (PC_W+1)'(4);
    localparam logic [PC_W:0]    END_WIDE   = {1'b0, END_ADDR};
    localparam logic [CNT_W-1:0] HANG_AT    = HANG_LIMIT - CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_AT = MAX_CYCLES - CNT_W'(1);

    logic [1:0]         state_q, state_d;
    logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [PC_W-1:0]    halt_pc_q, halt_pc_d;
    logic [PC_W-1:0]    prev_pc_q;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [CNT_W-1:0]   hang_cnt;
    logic [PC_W:0]      pc_plus4;
    logic [CAUSE_W-1:0] cause_now;
    logic               in_arm, in_run, pc_same;
    logic               end_hit, under_hit, hang_hit, timeout_hit;

    assign in_arm  = (state_q == ST_ARM);
    assign in_run  = (state_q == ST_RUN);
    assign pc_same = (pc == prev_pc_q);

    // one extra bit so a PC near the top of the space cannot wrap below END_ADDR
    assign pc_plus4    = {1'b0, pc} + PC_STEP;
    assign end_hit     = (pc_plus4 >= END_WIDE);
    assign under_hit   = (pc < START_ADDR);
    assign hang_hit    = (HANG_LIMIT != '0) && pc_same && (hang_cnt == HANG_AT);
    assign timeout_hit = (MAX_CYCLES != '0) && (cyc_cnt == TIMEOUT_AT);

    // RUN cycles elapsed; restarts every time the monitor passes through ARM
    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (in_arm),
        .inc   (in_run),
        .count (cyc_cnt)
    );

    // consecutive RUN cycles in which the PC did not move
    sat_counter #(.WIDTH(CNT_W)) u_hang_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (in_arm || (in_run && !pc_same)),
        .inc   (in_run && pc_same),
        .count (hang_cnt)
    );

    // pick the single highest-priority reason to stop this cycle
    always_comb begin
        cause_now = CAUSE_NONE;
        if (end_hit) begin
            cause_now = CAUSE_END;
        end else if (under_hit) begin
            cause_now = CAUSE_UNDERFLOW;
        end else if (ext_stop) begin
            cause_now = CAUSE_EXT;
        end else if (hang_hit) begin
            cause_now = CAUSE_HANG;
        end else if (timeout_hit) begin
            cause_now = CAUSE_TIMEOUT;
        end
    end

    // ARM waits out the delay, RUN checks every cycle, HALTED holds until reset
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        cause_d   = cause_q;
        halt_pc_d = halt_pc_q;
        case (state_q)
            ST_ARM: begin
                if (arm_cnt_q == ARM_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            ST_RUN: begin
                if (cause_now != CAUSE_NONE) begin
                    state_d   = ST_HALTED;
                    cause_d   = cause_now;
                    halt_pc_d = pc;
                end
            end
            default: begin
            end
        endcase
    end

    // state and latched result; previous PC tracks the fetch stream until halted
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ARM;
            arm_cnt_q <= '0;
            cause_q   <= CAUSE_NONE;
            halt_pc_q <= '0;
            prev_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            cause_q   <= cause_d;
            halt_pc_q <= halt_pc_d;
            if (state_q != ST_HALTED) begin
                prev_pc_q <= pc;
            end
        end
    end

    assign running    = in_run;
    assign halt       = (state_q == ST_HALTED);
    assign halt_cause = cause_q;
    assign halt_pc    = halt_pc_q;
    assign cycle_cnt  = cyc_cnt;

endmodule

// File: tb/tb_pc_run_monitor.sv
// tb/tb_pc_run_monitor.sv - checks several monitor configurations against a cycle model
module tb_pc_run_monitor;

    localparam int NI = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        ext_stop = 1'b0;

    logic [NI-1:0] run_w, halt_w;
    logic [2:0]    cause_w [NI];
    logic [31:0]   hpc_w   [NI];
    logic [31:0]   cnt_w   [NI];

    int unsigned checks = 0;
    int unsigned failures = 0;

    // configuration of each instance as seen by the model
    longint unsigned c_start [NI] = '{64'h3000, 64'h3000, 64'h3000, 64'h3000, 64'h3000, 64'h3000};
    longint unsigned c_end   [NI] = '{64'h4000, 64'h0, 64'hFFFF_FFFF, 64'h4000, 64'h4000, 64'h4000};
    longint unsigned c_arm   [NI] = '{0, 0, 0, 0, 0, 5};
    longint unsigned c_max   [NI] = '{0, 0, 0, 0, 20, 0};
    longint unsigned c_hang  [NI] = '{1024, 1024, 1024, 8, 1024, 1024};

    // model state: phase 0 arming, 1 running, 2 halted
    int              m_phase [NI];
    longint unsigned m_arm   [NI];
    longint unsigned m_cyc   [NI];
    longint unsigned m_eq    [NI];
    logic [31:0]     m_prev  [NI];
    logic [31:0]     m_hpc   [NI];
    logic [2:0]      m_cause [NI];

    always #5 clk = ~clk;

    pc_run_monitor u_def (
        .clk(clk), .reset(reset), .pc(pc), .ext_stop(ext_stop),
        .running(run_w[0]), .halt(halt_w[0]), .halt_cause(cause_w[0]),
        .halt_pc(hpc_w[0]), .cycle_cnt(cnt_w[0]));

    pc_run_monitor #(.END_ADDR(32'h0)) u_end0 (
        .clk(clk), .reset(reset), .pc(pc), .ext_stop(ext_stop),
        .running(run_w[1]), .halt(halt_w[1]), .halt_cause(cause_w[1]),
        .halt_pc(hpc_w[1]), .cycle_cnt(cnt_w[1]));

    pc_run_monitor #(.END_ADDR(32'hFFFF_FFFF)) u_endtop (
        .clk(clk), .reset(reset), .pc(pc), .ext_stop(ext_stop),
        .running(run_w[2]), .halt(halt_w[2]), .halt_cause(cause_w[2]),
        .halt_pc(hpc_w[2]), .cycle_cnt(cnt_w[2]));

    pc_run_monitor #(.HANG_LIMIT(32'd8)) u_hang (
        .clk(clk), .reset(reset), .pc(pc), .ext_stop(ext_stop),
        .running(run_w[3]), .halt(halt_w[3]), .halt_cause(cause_w[3]),
        .halt_pc(hpc_w[3]), .cycle_cnt(cnt_w[3]));

    pc_run_monitor #(.MAX_CYCLES(32'd20)) u_tmo (
        .clk(clk), .reset(reset), .pc(pc), .ext_stop(ext_stop),
        .running(run_w[4]), .halt(halt_w[4]), .halt_cause(cause_w[4]),
        .halt_pc(hpc_w[4]), .cycle_cnt(cnt_w[4]));

    pc_run_monitor #(.ARM_DELAY(5)) u_arm (
        .clk(clk), .reset(reset), .pc(pc), .ext_stop(ext_stop),
        .running(run_w[5]), .halt(halt_w[5]), .halt_cause(cause_w[5]),
        .halt_pc(hpc_w[5]), .cycle_cnt(cnt_w[5]));

    function automatic logic [68:0] dut_vec(int i);
        return {run_w[i], halt_w[i], cause_w[i], hpc_w[i], cnt_w[i]};
    endfunction

    function automatic logic [68:0] exp_vec(int i);
        return {m_phase[i] == 1, m_phase[i] == 2, m_cause[i], m_hpc[i], m_cyc[i][31:0]};
    endfunction

    // advance every model instance by one clock using the inputs present at the edge
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            logic [2:0] why;
            logic       same;
            if (reset) begin
                m_phase[i] = 0; m_arm[i] = 0; m_cyc[i] = 0; m_eq[i] = 0;
                m_prev[i] = '0; m_hpc[i] = '0; m_cause[i] = 3'd0;
            end else if (m_phase[i] == 0) begin
                if (m_arm[i] == c_arm[i]) begin
                    m_phase[i] = 1; m_cyc[i] = 0; m_eq[i] = 0;
                end else begin
                    m_arm[i] = m_arm[i] + 1;
                end
                m_prev[i] = pc;
            end else if (m_phase[i] == 1) begin
                same = (pc == m_prev[i]);
                why  = 3'd0;
                if ({32'b0, pc} + 64'd4 >= c_end[i])                         why = 3'd1;
                else if ({32'b0, pc} < c_start[i])                            why = 3'd2;
                else if (ext_stop)                                            why = 3'd5;
                else if (c_hang[i] != 0 && same && m_eq[i] + 1 >= c_hang[i])  why = 3'd3;
                else if (c_max[i] != 0 && m_cyc[i] + 1 >= c_max[i])           why = 3'd4;
                if (m_cyc[i] < 64'hFFFF_FFFF) m_cyc[i] = m_cyc[i] + 1;
                m_eq[i]   = same ? m_eq[i] + 1 : 0;
                m_prev[i] = pc;
                if (why != 3'd0) begin
                    m_phase[i] = 2; m_cause[i] = why; m_hpc[i] = pc;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ext_stop = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pc = 32'h2000;
        ext_stop = 1'b1;
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (dut_vec(i) !== 69'd0) begin
                failures++;
                $display("FAIL reset_zero inst=%0d got=%h exp=0", i, dut_vec(i));
            end
        end
        ext_stop = 1'b0;
    endtask

    task automatic test_end_walk();
        do_reset();
        pc = 32'h3000;
        tick();
        for (int k = 0; k < 1024; k++) begin
            pc = 32'h3000 + 32'(4 * k);
            tick();
            if (k % 64 == 0 || k >= 1022) begin
                for (int i = 0; i < NI; i++) begin
                    checks++;
                    if (dut_vec(i) !== exp_vec(i)) begin
                        failures++;
                        $display("FAIL end_walk k=%0d inst=%0d got=%h exp=%h", k, i, dut_vec(i), exp_vec(i));
                    end
                end
            end
        end
        checks++;
        if (dut_vec(0) !== {1'b0, 1'b1, 3'd1, 32'h3FFC, 32'h400}) begin
            failures++;
            $display("FAIL end_default got=%h exp=%h", dut_vec(0), {1'b0, 1'b1, 3'd1, 32'h3FFC, 32'h400});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        pc = 32'hFFFF_FFFC;
        tick();
        tick();
        checks++;
        if ({halt_w[1], cause_w[1], hpc_w[1]} !== {1'b1, 3'd1, 32'hFFFF_FFFC}) begin
            failures++;
            $display("FAIL wrap_end0 got=%h exp=%h", {halt_w[1], cause_w[1], hpc_w[1]}, {1'b1, 3'd1, 32'hFFFF_FFFC});
        end
        do_reset();
        pc = 32'hFFFF_FFF8;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (halt_w[2] !== 1'b0 || run_w[2] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_no_halt got=%b%b exp=01", halt_w[2], run_w[2]);
        end
        pc = 32'hFFFF_FFFC;
        tick();
        checks++;
        if ({halt_w[2], cause_w[2]} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL wrap_top_end got=%h exp=%h", {halt_w[2], cause_w[2]}, {1'b1, 3'd1});
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (dut_vec(i) !== exp_vec(i)) begin
                failures++;
                $display("FAIL wrap_model inst=%0d got=%h exp=%h", i, dut_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_hang();
        do_reset();
        pc = 32'h3010;
        tick();
        for (int k = 1; k <= 7; k++) tick();
        checks++;
        if (halt_w[3] !== 1'b0) begin
            failures++;
            $display("FAIL hang_early got=%b exp=0", halt_w[3]);
        end
        tick();
        checks++;
        if ({halt_w[3], cause_w[3], hpc_w[3]} !== {1'b1, 3'd3, 32'h3010}) begin
            failures++;
            $display("FAIL hang_fire got=%h exp=%h", {halt_w[3], cause_w[3], hpc_w[3]}, {1'b1, 3'd3, 32'h3010});
        end
        do_reset();
        pc = 32'h3010;
        tick();
        for (int k = 1; k <= 10; k++) begin
            pc = (k >= 7) ? 32'h3014 : 32'h3010;
            tick();
        end
        checks++;
        if (halt_w[3] !== 1'b0) begin
            failures++;
            $display("FAIL hang_broken got=%b exp=0", halt_w[3]);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (dut_vec(i) !== exp_vec(i)) begin
                failures++;
                $display("FAIL hang_model inst=%0d got=%h exp=%h", i, dut_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            pc = 32'h3000;
            tick();
            for (int k = 0; k < 20; k++) begin
                pc = (pass == 1 && k == 19) ? 32'h2FFC : 32'h3000 + 32'(4 * k);
                tick();
            end
            checks++;
            if (pass == 0 && dut_vec(4) !== {1'b0, 1'b1, 3'd4, 32'h304C, 32'd20}) begin
                failures++;
                $display("FAIL timeout got=%h exp=%h", dut_vec(4), {1'b0, 1'b1, 3'd4, 32'h304C, 32'd20});
            end
            if (pass == 1 && dut_vec(4) !== {1'b0, 1'b1, 3'd2, 32'h2FFC, 32'd20}) begin
                failures++;
                $display("FAIL timeout_prio got=%h exp=%h", dut_vec(4), {1'b0, 1'b1, 3'd2, 32'h2FFC, 32'd20});
            end
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL timeout_model pass=%0d inst=%0d got=%h exp=%h", pass, i, dut_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_arm();
        do_reset();
        pc = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            ext_stop = (k == 2 || k == 3);
            tick();
        end
        ext_stop = 1'b0;
        checks++;
        if ({run_w[5], halt_w[5], cnt_w[5]} !== {1'b1, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL arm_enter got=%h exp=%h", {run_w[5], halt_w[5], cnt_w[5]}, {1'b1, 1'b0, 32'd0});
        end
        tick();
        checks++;
        if (dut_vec(5) !== {1'b0, 1'b1, 3'd2, 32'h0, 32'd1}) begin
            failures++;
            $display("FAIL arm_underflow got=%h exp=%h", dut_vec(5), {1'b0, 1'b1, 3'd2, 32'h0, 32'd1});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pc = 32'h3000;
        tick();
        for (int k = 0; k < 10; k++) begin
            pc = pc + 32'd4;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (dut_vec(0) !== 69'd0) begin
            failures++;
            $display("FAIL reset_mid_run got=%h exp=0", dut_vec(0));
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            pc = pc + 32'd4;
            tick();
        end
        checks++;
        if ({run_w[0], cnt_w[0]} !== {1'b1, 32'd3}) begin
            failures++;
            $display("FAIL reset_restart got=%h exp=%h", {run_w[0], cnt_w[0]}, {1'b1, 32'd3});
        end
        reset = 1'b1;
        pc = 32'h2000;
        tick();
        reset = 1'b0;
        checks++;
        if (dut_vec(0) !== 69'd0) begin
            failures++;
            $display("FAIL reset_beats_detect got=%h exp=0", dut_vec(0));
        end
        tick();
        tick();
        tick();
        checks++;
        if ({halt_w[0], cause_w[0]} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL halted_setup got=%h exp=%h", {halt_w[0], cause_w[0]}, {1'b1, 3'd2});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (dut_vec(0) !== 69'd0) begin
            failures++;
            $display("FAIL reset_halted got=%h exp=0", dut_vec(0));
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 16; r++) begin
            int hold_bias;
            hold_bias = (r % 4 == 0) ? 7 : 2;
            do_reset();
            pc = 32'h3000 + 32'($urandom_range(0, 255) * 4);
            for (int c = 0; c < 60; c++) begin
                int op;
                op = $urandom_range(0, 9);
                if (op < hold_bias)       pc = pc;
                else if (op < 8)          pc = pc + 32'd4;
                else                      pc = 32'h2FF0 + 32'($urandom_range(0, 1032) * 4);
                ext_stop = ($urandom_range(0, 24) == 0);
                reset    = ($urandom_range(0, 49) == 0);
                tick();
                for (int i = 0; i < NI; i++) begin
                    checks++;
                    if (dut_vec(i) !== exp_vec(i)) begin
                        failures++;
                        $display("FAIL random r=%0d c=%0d inst=%0d got=%h exp=%h", r, c, i, dut_vec(i), exp_vec(i));
                    end
                end
            end
            reset = 1'b0;
            ext_stop = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_end_walk();
        test_wrap();
        test_hang();
        test_timeout();
        test_arm();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
